dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised data-memory load/store unit: the next-generation data memory for the MIPS32 core. It replaces the plain word-wide RAM with byte, halfword and word (and doubleword at 64 bits) access, sign/zero extension, misalignment detection, a configurable read pipeline, and a valid/ready request port. A post-reset clear sequencer zeroes the array one word per cycle, so the array maps onto block RAM instead of needing a reset-wide flop clear. It sits between the core's MEM stage and the on-chip RAM.

## Interface
- DWIDTH, 32: data width; 32 or 64 only. BW = log2(DWIDTH/8).
- AWIDTH, 10: word-index bits; depth = 2**AWIDTH words.
- RD_LAT, 1: response latency in cycles; 1..4.
- CLEAR_ON_RESET, 1: 1 = run the clear sweep after reset; 0 = skip it (array contents undefined).
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  AWIDTH+BW  byte address; upper AWIDTH bits = word index, low BW bits = byte offset.
- req_size  in  2  00 byte, 01 half, 10 32-bit word, 11 64-bit (legal only when DWIDTH=64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  DWIDTH  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DWIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal size; qualified by rsp_valid.

## Operation
- The FSM has two states, CLEAR and READY. rst forces CLEAR when CLEAR_ON_RESET=1, otherwise READY.
- CLEAR state:
  - clr_cnt starts at 0. Each cycle it writes 0 to word clr_cnt, then increments.
  - After writing word 2**AWIDTH-1, the FSM moves to READY.
  - req_ready=0 throughout CLEAR.
- req_ready = (state==READY) & ~rst. The unit never stalls in READY.
- Acceptance: a request is accepted when req_valid & req_ready at a rising edge. Every accepted request produces exactly one response.
- Legality:
  - Half needs offset[0]=0. Word needs offset[1:0]=0. 64-bit needs offset=0.
  - size 11 with DWIDTH=32 is illegal.
  - An illegal request performs no array access. Its response has rsp_err=1 and rsp_rdata=0.
- Lane mapping is little-endian: byte offset k maps to array bits [8k+7:8k].
- Store:
  - The low 8/16/32/64 bits of req_wdata are written into the addressed lanes only. Other lanes are unchanged.
  - The write commits at the acceptance edge.
  - Response: rsp_err=0, rsp_rdata=0.
- Load:
  - The array is read at the acceptance edge and the addressed lanes are extracted.
  - The extracted value is sign- or zero-extended to DWIDTH per req_unsigned.
  - A 64-bit load, or a 32-bit load when DWIDTH=32, ignores req_unsigned.
- Ordering: requests complete in order. A load accepted the cycle after a store to the same word returns the stored data.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clr_cnt=0. The response pipeline is flushed.
- Latency: a request accepted at edge N gives rsp_valid=1 in the cycle after edge N+RD_LAT-1. For RD_LAT=1 that is the cycle immediately after acceptance.
- Throughput: one request per cycle, with no response backpressure.
- rsp_rdata and rsp_err hold their last values while rsp_valid=0.
- Clear duration: with CLEAR_ON_RESET=1, req_ready rises exactly 2**AWIDTH rising edges after rst deasserts. With CLEAR_ON_RESET=0, it rises as soon as rst deasserts.
- rst asserted mid-operation:
  - Outputs go to their reset values immediately.
  - In-flight responses are dropped and never emitted.
  - A partially completed clear restarts from word 0.
  - Stores already committed remain in the array when CLEAR_ON_RESET=0.
- req_valid while req_ready=0 is ignored; no response is generated.

## Test plan
- Clear sweep: AWIDTH=4, CLEAR_ON_RESET=1. Deassert rst, count edges until req_ready=1 -> exactly 16. Load word at 0x3C -> rdata=0x00000000.
- Store/load sizes: sw 0x80F0A5C3 @0x10; then lb @0x11 -> 0xFFFFFFA5; lbu @0x11 -> 0x000000A5; lh @0x12 -> 0xFFFF80F0; lhu @0x12 -> 0x000080F0.
- Partial store: sw 0x11223344 @0x20, sb 0xAB @0x22, sh 0xBEEF @0x20; lw @0x20 -> 0x11ABBEEF.
- Misalignment: lh @0x01 -> rsp_err=1, rdata=0. sw @0x06 -> rsp_err=1 and the array is unchanged. size=11 at DWIDTH=32 -> rsp_err=1.
- Latency/back-to-back: RD_LAT=3. Accept sw 0xDEADBEEF @0x40 then lw @0x40 on consecutive edges -> two rsp_valid pulses, 3 and 4 cycles after the store. The second pulse carries 0xDEADBEEF.
- Reset mid-flight: RD_LAT=2. Assert rst one cycle after accepting a load -> no rsp_valid ever appears for it. After deassert, the clear restarts and req_ready stays low for 2**AWIDTH edges.

Source files
------------

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: byte/half/word/dword access with sign/zero extension,
// misalignment detection, post-reset clear sweep and a fixed-latency response pipeline.
module dmem_lsu #(
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned AWIDTH         = 10,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_we,
    input  logic [AWIDTH+$clog2(DWIDTH/8)-1:0]     req_addr,
    input  logic [1:0]                             req_size,
    input  logic                                   req_unsigned,
    input  logic [DWIDTH-1:0]                      req_wdata,
    output logic                                   rsp_valid,
    output logic [DWIDTH-1:0]                      rsp_rdata,
    output logic                                   rsp_err
);

    localparam int unsigned NB    = DWIDTH / 8;
    localparam int unsigned BW    = $clog2(NB);
    localparam int unsigned DEPTH = 2 ** AWIDTH;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] clr_cnt, clr_nxt;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-1:0] idx_c;
    logic [BW-1:0]     off_c;
    logic              illegal_c;
    logic              accept_c;
    logic              store_c;
    logic [NB-1:0]     size_mask_c;
    logic [NB-1:0]     be_c;
    logic [DWIDTH-1:0] wdata_sh_c;
    logic [DWIDTH-1:0] rd_sh_c;
    logic [DWIDTH-1:0] lane_mask_c;
    logic              sign_c;
    logic [DWIDTH-1:0] rsp_d_c;

    logic [RD_LAT-1:0] pipe_v;
    logic [DWIDTH-1:0] pipe_d [RD_LAT];
    logic              pipe_e [RD_LAT];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_nxt;
        end
    end

    // Clear sweep walks every word once, then hands over to READY
    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_cnt;
        if (state == S_CLEAR) begin
            clr_nxt = clr_cnt + AWIDTH'(1);
            if (clr_cnt == '1) begin
                state_nxt = S_READY;
            end
        end
    end

    assign req_ready = (state == S_READY) & ~rst;
    assign accept_c  = req_valid & req_ready;
    assign idx_c     = req_addr[AWIDTH+BW-1:BW];
    assign off_c     = req_addr[BW-1:0];

    // Legality and lane enables
    always_comb begin
        illegal_c   = 1'b0;
        size_mask_c = '1;
        unique case (req_size)
            2'b00: begin
                size_mask_c = NB'(1);
            end
            2'b01: begin
                size_mask_c = NB'(3);
                illegal_c   = off_c[0];
            end
            2'b10: begin
                size_mask_c = NB'(8'h0F);
                illegal_c   = (off_c[1:0] != 2'b00);
            end
            default: begin
                size_mask_c = '1;
                illegal_c   = (DWIDTH != 64) || (off_c != '0);
            end
        endcase
    end

    assign store_c    = accept_c & req_we & ~illegal_c;
    assign be_c       = size_mask_c << off_c;
    assign wdata_sh_c = req_wdata << {off_c, 3'b000};

    // Array: clear sweep has the write port while in CLEAR; stores merge by lane
    always_ff @(posedge clk) begin
        if ((state == S_CLEAR) && !rst) begin
            mem[clr_cnt] <= '0;
        end else if (store_c) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= wdata_sh_c[8*b +: 8];
                end
            end
        end
    end

    // Load extraction and extension; full-width loads ignore req_unsigned via the mask
    always_comb begin
        rd_sh_c     = mem[idx_c] >> {off_c, 3'b000};
        lane_mask_c = '1;
        sign_c      = rd_sh_c[DWIDTH-1];
        unique case (req_size)
            2'b00: begin
                lane_mask_c = DWIDTH'(8'hFF);
                sign_c      = rd_sh_c[7];
            end
            2'b01: begin
                lane_mask_c = DWIDTH'(16'hFFFF);
                sign_c      = rd_sh_c[15];
            end
            2'b10: begin
                lane_mask_c = DWIDTH'(32'hFFFF_FFFF);
                sign_c      = rd_sh_c[31];
            end
            default: begin
                lane_mask_c = '1;
                sign_c      = rd_sh_c[DWIDTH-1];
            end
        endcase
        rsp_d_c = rd_sh_c & lane_mask_c;
        if (!req_unsigned && sign_c) begin
            rsp_d_c = rsp_d_c | ~lane_mask_c;
        end
        if (req_we || illegal_c) begin
            rsp_d_c = '0;
        end
    end

    // Response pipeline; payload stages only advance with a valid so outputs hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_d[i] <= '0;
                pipe_e[i] <= 1'b0;
            end
        end else begin
            pipe_v[0] <= accept_c;
            if (accept_c) begin
                pipe_d[0] <= rsp_d_c;
                pipe_e[0] <= illegal_c;
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                    pipe_e[i] <= pipe_e[i-1];
                end
            end
        end
    end

    assign rsp_valid = pipe_v[RD_LAT-1];
    assign rsp_rdata = pipe_d[RD_LAT-1];
    assign rsp_err   = pipe_e[RD_LAT-1];

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vector table, latency and reset sequences,
// then random traffic against a byte-array reference model with an in-order scoreboard.
module tb_dmem_lsu;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 3;
    localparam int unsigned NBT = (2 ** AW) * (DW / 8);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [6:0]    req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    always #5 clk = ~clk;

    dmem_lsu #(
        .DWIDTH        (DW),
        .AWIDTH        (AW),
        .RD_LAT        (LAT),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        tbl [20];
    logic [7:0]  mm [NBT];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: little-endian byte array, extension by two's-complement arithmetic
    task automatic model(input logic we, input logic [6:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        int nb = 1 << sz;
        longint unsigned v = 0;
        rd  = '0;
        err = (sz == 2'd3) || ((int'(a) % nb) != 0);
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mm[int'(a) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) v = v | (longint'(mm[int'(a) + i]) << (8 * i));
            if (!uns && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
            rd = v[31:0];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NBT; i++) mm[i] = 8'h00;
    endtask

    task automatic issue(input vec_t v, input logic use_tbl, input string name);
        logic [31:0] mrd;
        logic        merr;
        exp_t        e;
        check({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_addr     = v.addr;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_wdata    = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model(v.we, v.addr, v.size, v.uns, v.wdata, mrd, merr);
        e.due = cyc + int'(LAT) - 1;
        e.rd  = use_tbl ? v.rd : mrd;
        e.err = use_tbl ? v.err : merr;
        sb.push_back(e);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready) break;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, 32'(req_ready), 32'd0);
        check({name, "_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_rdata"}, rsp_rdata, 32'd0);
        check({name, "_err"},   32'(rsp_err), 32'd0);
    endtask

    // Response monitor: in-order scoreboard, latency, and hold-while-idle
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            last_rd  = '0;
            last_err = 1'b0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: rdata 0x%08h err %0d with nothing outstanding (cycle %0d)",
                         rsp_rdata, rsp_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                check("rsp_rdata", rsp_rdata, mon_e.rd);
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
            last_rd  = rsp_rdata;
            last_err = rsp_err;
        end else begin
            check("hold_rdata", rsp_rdata, last_rd);
            check("hold_err", 32'(rsp_err), 32'(last_err));
        end
    end

    initial begin
        int   n;
        vec_t v;

        tbl[0]  = '{1'b0, 7'h3C, 2'd2, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b1, 7'h10, 2'd2, 1'b0, 32'h80F0A5C3, 32'h0000_0000, 1'b0};
        tbl[2]  = '{1'b0, 7'h11, 2'd0, 1'b0, 32'h0,        32'hFFFF_FFA5, 1'b0};
        tbl[3]  = '{1'b0, 7'h11, 2'd0, 1'b1, 32'h0,        32'h0000_00A5, 1'b0};
        tbl[4]  = '{1'b0, 7'h12, 2'd1, 1'b0, 32'h0,        32'hFFFF_80F0, 1'b0};
        tbl[5]  = '{1'b0, 7'h12, 2'd1, 1'b1, 32'h0,        32'h0000_80F0, 1'b0};
        tbl[6]  = '{1'b0, 7'h10, 2'd2, 1'b1, 32'h0,        32'h80F0_A5C3, 1'b0};
        tbl[7]  = '{1'b1, 7'h20, 2'd2, 1'b0, 32'h11223344, 32'h0000_0000, 1'b0};
        tbl[8]  = '{1'b1, 7'h22, 2'd0, 1'b0, 32'h123456AB, 32'h0000_0000, 1'b0};
        tbl[9]  = '{1'b1, 7'h20, 2'd1, 1'b0, 32'h9999BEEF, 32'h0000_0000, 1'b0};
        tbl[10] = '{1'b0, 7'h20, 2'd2, 1'b0, 32'h0,        32'h11AB_BEEF, 1'b0};
        tbl[11] = '{1'b0, 7'h01, 2'd1, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
        tbl[12] = '{1'b1, 7'h06, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0000_0000, 1'b1};
        tbl[13] = '{1'b0, 7'h04, 2'd2, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
        tbl[14] = '{1'b0, 7'h20, 2'd3, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
        tbl[15] = '{1'b0, 7'h23, 2'd0, 1'b0, 32'h0,        32'h0000_0011, 1'b0};
        tbl[16] = '{1'b0, 7'h21, 2'd1, 1'b1, 32'h0,        32'h0000_0000, 1'b1};
        tbl[17] = '{1'b0, 7'h20, 2'd0, 1'b0, 32'h0,        32'hFFFF_FFEF, 1'b0};
        tbl[18] = '{1'b0, 7'h13, 2'd0, 1'b1, 32'h0,        32'h0000_0080, 1'b0};
        tbl[19] = '{1'b0, 7'h13, 2'd0, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b0};

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Requests offered during the sweep must be ignored
        req_valid = 1'b1;
        req_addr  = 7'h3C;
        req_size  = 2'd2;
        rst       = 1'b0;
        #1;
        check("clear_start_ready", 32'(req_ready), 32'd0);
        wait_ready(n);
        check("clear_len", 32'(n), 32'(2 ** AW));

        for (int i = 0; i < 20; i++) issue(tbl[i], 1'b1, $sformatf("vec%0d", i));
        drain();

        // Back-to-back store then load to the same word
        v = '{1'b1, 7'h40, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0};
        issue(v, 1'b1, "b2b_sw");
        v = '{1'b0, 7'h40, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0};
        issue(v, 1'b1, "b2b_lw");
        drain();

        // Reset with a load in flight: the response must never appear
        v = '{1'b1, 7'h44, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b0};
        issue(v, 1'b1, "pre_sw");
        v = '{1'b0, 7'h44, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b0};
        issue(v, 1'b1, "pre_lw");
        drain();
        check("pre_rst_rdata", rsp_rdata, 32'h12345678);
        v = '{1'b0, 7'h44, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0};
        issue(v, 1'b1, "flight_lw");
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        clear_model();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        rst = 1'b0;
        #1;
        check("reclear_start_ready", 32'(req_ready), 32'd0);
        wait_ready(n);
        check("reclear_len", 32'(n), 32'(2 ** AW));
        v = '{1'b0, 7'h44, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0};
        issue(v, 1'b1, "reclear_lw");
        drain();

        // Random traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_addr = 7'($urandom);
                @(posedge clk);
                #1;
            end else begin
                v.we    = 1'($urandom_range(0, 1));
                v.addr  = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 15))
                                                      : 7'($urandom_range(0, 127));
                v.size  = 2'($urandom_range(0, 3));
                v.uns   = 1'($urandom_range(0, 1));
                v.wdata = $urandom;
                v.rd    = '0;
                v.err   = 1'b0;
                issue(v, 1'b0, "rnd");
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
